// File: rtl/spi_rx.sv
// SPI receiver: oversamples spi_clock/spi_data on the system clock, assembles MSB-first frames
// and presents each completed frame on a valid/ready output register.
module spi_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_clock,
    input  logic                  spi_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  overrun,
    output logic                  frame_error,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] sdat_sync_q;
    logic                   sclk_prev_q;

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [IW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  ferr_q, ferr_d;

    logic                  sclk_s;
    logic                  sdat_s;
    logic                  rise;
    logic                  complete;
    logic [DATA_WIDTH-1:0] shifted;
    logic [IW-1:0]         idle_next;

    // Both paths share the same depth so the sampled data bit lines up with its rise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            sdat_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clock};
            sdat_sync_q <= {sdat_sync_q[SYNC_STAGES-2:0], spi_data};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign sdat_s  = sdat_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign shifted = (shift_q << 1) | DATA_WIDTH'(sdat_s);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            idle_cnt_q <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        idle_cnt_d = idle_cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        overrun_d  = 1'b0;
        ferr_d     = 1'b0;
        complete   = 1'b0;
        idle_next  = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IW'(1);

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d  = '0;
                idle_cnt_d = '0;
                if (rise) begin
                    shift_d = shifted;
                    if (DATA_WIDTH == 1) begin
                        complete = 1'b1;
                    end else begin
                        bit_cnt_d = CW'(1);
                        state_d   = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                if (rise) begin
                    shift_d    = shifted;
                    idle_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        complete  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (idle_next == IDLE_MAX) begin
                    // Transmitter stalled mid-frame: drop the partial byte
                    ferr_d     = 1'b1;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    idle_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte may land in the same cycle the consumer drains the old one
        if (complete) begin
            if (!valid_q || data_ready) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign overrun     = overrun_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q == ST_RECV);

endmodule

// File: tb/tb_spi_rx.sv
// Directed and randomized bench for spi_rx, checked against a byte-level model of the receiver.
module tb_spi_rx;

    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int TO  = 64;
    localparam int PH  = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          spi_clock;
    logic          spi_data;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready;
    logic          overrun;
    logic          frame_error;
    logic          busy;

    spi_rx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .spi_clock   (spi_clock),
        .spi_data    (spi_data),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overrun     (overrun),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model of the output register
    logic          model_valid = 1'b0;
    logic [DW-1:0] model_byte  = '0;
    logic [DW-1:0] exp_q[$];
    int            exp_ovr = 0;
    int            exp_fe  = 0;
    bit            ready_held = 1'b0;

    int ovr_seen  = 0;
    int fe_seen   = 0;
    int both_seen = 0;
    int fe_cyc    = 0;
    int rise_cyc  = 0;

    logic          pre_valid;
    logic          post_valid;
    logic [DW-1:0] post_data;
    logic          post_ovr;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (overrun) ovr_seen = ovr_seen + 1;
        if (frame_error) begin
            fe_seen = fe_seen + 1;
            fe_cyc  = cyc;
        end
        if (overrun && frame_error) both_seen = both_seen + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit last, input bit pulse);
        @(negedge clock);
        spi_data = b;
        repeat (PH) @(negedge clock);
        spi_clock = 1'b1;
        rise_cyc  = cyc;
        if (last) begin
            repeat (SS) @(negedge clock);
            pre_valid = data_valid;
            if (pulse) data_ready = 1'b1;
            @(negedge clock);
            if (pulse) data_ready = 1'b0;
            post_valid = data_valid;
            post_data  = data_out;
            post_ovr   = overrun;
            repeat (PH - SS - 1) @(negedge clock);
        end else begin
            repeat (PH) @(negedge clock);
        end
        spi_clock = 1'b0;
    endtask

    task automatic send_byte(input logic [DW-1:0] val, input bit pulse, input string tag);
        logic [DW-1:0] tmp;
        logic          exp_pre;
        logic          accepted;
        tmp = val;
        for (int i = DW - 1; i >= 0; i--) send_bit(tmp[i], i == 0, pulse);
        spi_data = 1'b1;
        exp_pre  = model_valid;
        accepted = !model_valid || pulse || ready_held;
        if (accepted) model_byte = val;
        else exp_ovr++;
        exp_q.push_back(model_byte);
        chk({tag, "_valid_pre"}, 32'(pre_valid), 32'(exp_pre));
        chk({tag, "_valid_post"}, 32'(post_valid), 32'd1);
        chk({tag, "_data"}, 32'(post_data), 32'(exp_q.pop_front()));
        chk({tag, "_overrun"}, 32'(post_ovr), accepted ? 32'd0 : 32'd1);
        model_valid = ready_held ? 1'b0 : 1'b1;
    endtask

    task automatic drain(input string tag);
        @(negedge clock);
        chk({tag, "_hold_valid"}, 32'(data_valid), 32'(model_valid));
        chk({tag, "_hold_data"}, 32'(data_out), 32'(model_byte));
        data_ready = 1'b1;
        @(negedge clock);
        data_ready  = 1'b0;
        model_valid = 1'b0;
        chk({tag, "_after_drain"}, 32'(data_valid), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] rv;
        int            mode;
        int            d;
        int            ovr_before;
        int            fe_before;

        reset      = 1'b0;
        spi_clock  = 1'b0;
        spi_data   = 1'b1;
        data_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("idle_valid", 32'(data_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single byte held until the consumer pulses ready
        send_byte(8'hA5, 1'b0, "a5");
        repeat (10) @(negedge clock);
        chk("a5_still_valid", 32'(data_valid), 32'd1);
        drain("a5");

        // Back-to-back with ready held high
        ready_held = 1'b1;
        data_ready = 1'b1;
        send_byte(8'h3C, 1'b0, "3c");
        chk("3c_hs_clear", 32'(data_valid), 32'd0);
        send_byte(8'hC3, 1'b0, "c3");
        chk("c3_hs_clear", 32'(data_valid), 32'd0);
        ready_held = 1'b0;
        data_ready = 1'b0;

        // Overrun: second byte dropped while first is held
        send_byte(8'h11, 1'b0, "11");
        send_byte(8'h22, 1'b0, "22");
        repeat (5) @(negedge clock);
        chk("ovr_count", 32'(ovr_seen), 32'(exp_ovr));
        drain("11");

        // Ready asserted exactly in the completion cycle
        send_byte(8'h77, 1'b0, "77");
        send_byte(8'h99, 1'b1, "99");
        drain("99");

        // Stalled partial frame aborts on timeout
        fe_before = fe_seen;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        chk("stall_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 90 && fe_seen == fe_before; i++) @(negedge clock);
        exp_fe++;
        chk("fe_count", 32'(fe_seen), 32'(exp_fe));
        d = fe_cyc - rise_cyc;
        chk("fe_delay_window", 32'(d >= TO + SS && d <= TO + SS + 2), 32'd1);
        chk("fe_no_valid", 32'(data_valid), 32'd0);
        chk("fe_busy", 32'(busy), 32'd0);
        send_byte(8'h81, 1'b0, "81");
        drain("81");

        // Reset mid-frame with a byte held
        send_byte(8'h3E, 1'b0, "3e");
        for (int i = 0; i < 5; i++) send_bit(rv_bit(8'h5A, 7 - i), 1'b0, 1'b0);
        @(negedge clock);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        ovr_before = ovr_seen;
        fe_before  = fe_seen;
        reset = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        chk("mid_rst_fe", 32'(frame_error), 32'd0);
        model_valid = 1'b0;
        model_byte  = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_no_pulses", 32'((ovr_seen - ovr_before) + (fe_seen - fe_before)), 32'd0);
        send_byte(8'h5A, 1'b0, "5a");
        drain("5a");

        // Randomized traffic with mixed consumer behaviour
        for (int n = 0; n < 12; n++) begin
            rv   = DW'($urandom_range(0, 255));
            mode = $urandom_range(0, 2);
            if (mode == 0 && model_valid) drain("rnd_pre");
            send_byte(rv, mode == 2, "rnd");
        end
        if (model_valid) drain("rnd_end");

        repeat (5) @(negedge clock);
        chk("final_ovr_count", 32'(ovr_seen), 32'(exp_ovr));
        chk("final_fe_count", 32'(fe_seen), 32'(exp_fe));
        chk("never_both", 32'(both_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic logic rv_bit(input logic [DW-1:0] v, input int idx);
        return v[idx];
    endfunction

endmodule
